atm_account_ledger: RTL and testbench

//  Account-side responder for the ATM session controller. Serves FIND, AUTH, READ, DEBIT,

---
 rtl/atm_ledger_pkg.sv | 57 +++++
 rtl/atm_acc_search.sv | 52 +++++
 rtl/atm_account_ledger.sv | 203 ++++++++++++++++++++
 tb/tb_atm_account_ledger.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/atm_ledger_pkg.sv
// Shared encodings, account/PIN tables and request record for the account ledger.
// The lockout feature is compiled in with LEDGER_LOCKOUT_EN.
package atm_ledger_pkg;

    localparam int N_ACC     = 10;
    localparam int ACC_WIDTH = 12;
    localparam int PIN_WIDTH = 4;
    localparam int BAL_WIDTH = 11;
    localparam int AMT_WIDTH = 12;
    localparam int MAX_BAL   = 2047;

    typedef enum logic [2:0] {
        OP_FIND     = 3'd0,
        OP_AUTH     = 3'd1,
        OP_READ     = 3'd2,
        OP_DEBIT    = 3'd3,
        OP_CREDIT   = 3'd4,
        OP_TRANSFER = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_NOT_FOUND    = 3'd1,
        ST_BAD_PIN      = 3'd2,
        ST_INSUFFICIENT = 3'd3,
        ST_OVERFLOW     = 3'd4,
        ST_BAD_OP       = 3'd5,
        ST_LOCKED       = 3'd6
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE, S_SRC_SEARCH, S_DST_SEARCH, S_EXEC, S_RESP
    } state_e;

    localparam logic [ACC_WIDTH-1:0] ACC_TABLE [N_ACC] = '{
        12'd2178, 12'd2816, 12'd1024, 12'd1357, 12'd1500,
        12'd1800, 12'd2000, 12'd2468, 12'd3000, 12'd3333
    };

    localparam logic [PIN_WIDTH-1:0] PIN_TABLE [N_ACC] = '{
        4'b0100, 4'b0110, 4'b0001, 4'b0010, 4'b0011,
        4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b1010
    };

    typedef struct packed {
        logic [2:0]           op;
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH-1:0] dst;
        logic [PIN_WIDTH-1:0] pin;
        logic [AMT_WIDTH-1:0] amount;
    } req_t;

    function automatic logic is_reserved(input logic [2:0] op);
        return op > 3'd5;
    endfunction

endpackage

// File: rtl/atm_acc_search.sv
// Sequential account lookup: compares one table entry per cycle, first compare in the start cycle.
// done/found/index are a one-cycle registered result; key must stay stable while busy.
module atm_acc_search
    import atm_ledger_pkg::*;
#(
    parameter int NUM_ACC = N_ACC,
    parameter int ACC_W   = ACC_WIDTH,
    parameter int IDX_W   = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] idx, cur_idx;
    logic             hit, last;

    always_comb begin
        cur_idx = start ? '0 : idx;
        hit     = (ACC_TABLE[cur_idx] == key);
        last    = (cur_idx == IDX_W'(NUM_ACC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            found <= 1'b0;
            index <= '0;
            idx   <= '0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                if (hit || last) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    found <= hit;
                    index <= cur_idx;
                end else begin
                    busy <= 1'b1;
                    idx  <= cur_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/atm_account_ledger.sv
// Account ledger responder: owns all balances, serves FIND/AUTH/READ/DEBIT/CREDIT/TRANSFER.
// Define LEDGER_LOCKOUT_EN to build per-account bad-PIN counters and the LOCKED status.
module atm_account_ledger
    import atm_ledger_pkg::*;
#(
    parameter int NUM_ACC = N_ACC,
    parameter int ACC_W   = ACC_WIDTH,
    parameter int PIN_W   = PIN_WIDTH,
    parameter int BAL_W   = BAL_WIDTH,
    parameter int AMT_W   = AMT_WIDTH,
    parameter int DEF_BAL = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ACC_W-1:0] req_acc,
    input  logic [PIN_W-1:0] req_pin,
    input  logic [ACC_W-1:0] req_dst_acc,
    input  logic [AMT_W-1:0] req_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [BAL_W-1:0] rsp_balance
);

    localparam int IDX_W = $clog2(NUM_ACC);
    localparam int AW1   = AMT_W + 1;

    state_e                      state, state_nxt;
    req_t                        req;
    logic [IDX_W-1:0]            src_idx, dst_idx;
    logic [NUM_ACC-1:0][BAL_W-1:0] bal;
    status_e                     st_q;
    logic [BAL_W-1:0]            bal_q;

    logic             accept, src_hit, s_start, s_busy, s_done, s_found;
    logic [ACC_W-1:0] s_key;
    logic [IDX_W-1:0] s_index;

    logic [BAL_W-1:0] src_bal, dst_bal, src_new, dst_new;
    logic [AW1-1:0]   sb, db, amt;
    status_e          ex_st;
    logic             wr_src, wr_dst;

`ifdef LEDGER_LOCKOUT_EN
    logic [NUM_ACC-1:0][1:0] bad_cnt;
    logic                    locked;
`endif

    assign req_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);
    assign rsp_status  = st_q;
    assign rsp_balance = bal_q;
    assign accept      = req_valid && req_ready;
    assign src_hit     = (state == S_SRC_SEARCH) && s_done && s_found;

    // The destination search launches in the same cycle the source hit lands.
    assign s_start = ((state == S_SRC_SEARCH) && !s_busy && !s_done) ||
                     (src_hit && req.op == OP_TRANSFER);
    assign s_key   = (state == S_DST_SEARCH || src_hit) ? req.dst : req.acc;

    atm_acc_search #(.NUM_ACC(NUM_ACC), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_search (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s_start),
        .key   (s_key),
        .busy  (s_busy),
        .done  (s_done),
        .found (s_found),
        .index (s_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (accept) state_nxt = is_reserved(req_op) ? S_RESP : S_SRC_SEARCH;
            S_SRC_SEARCH: if (s_done) begin
                              if (!s_found)                    state_nxt = S_RESP;
                              else if (req.op == OP_TRANSFER)  state_nxt = S_DST_SEARCH;
                              else                             state_nxt = S_EXEC;
                          end
            S_DST_SEARCH: if (s_done) state_nxt = s_found ? S_EXEC : S_RESP;
            S_EXEC:       state_nxt = S_RESP;
            S_RESP:       if (rsp_ready) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Widened arithmetic so neither sum nor comparison can wrap.
    always_comb begin
        src_bal = bal[src_idx];
        dst_bal = bal[dst_idx];
        sb      = AW1'(src_bal);
        db      = AW1'(dst_bal);
        amt     = AW1'(req.amount);
        ex_st   = ST_OK;
        src_new = src_bal;
        dst_new = dst_bal;
        wr_src  = 1'b0;
        wr_dst  = 1'b0;
        case (req.op)
            OP_AUTH:   if (req.pin != PIN_TABLE[src_idx]) ex_st = ST_BAD_PIN;
            OP_DEBIT:  if (amt > sb) ex_st = ST_INSUFFICIENT;
                       else begin
                           src_new = BAL_W'(sb - amt);
                           wr_src  = 1'b1;
                       end
            OP_CREDIT: if (sb + amt > AW1'(MAX_BAL)) ex_st = ST_OVERFLOW;
                       else begin
                           src_new = BAL_W'(sb + amt);
                           wr_src  = 1'b1;
                       end
            OP_TRANSFER: begin
                if (amt > sb) ex_st = ST_INSUFFICIENT;
                else if (src_idx != dst_idx) begin
                    if (db + amt > AW1'(MAX_BAL)) ex_st = ST_OVERFLOW;
                    else begin
                        src_new = BAL_W'(sb - amt);
                        dst_new = BAL_W'(db + amt);
                        wr_src  = 1'b1;
                        wr_dst  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
`ifdef LEDGER_LOCKOUT_EN
        locked = (bad_cnt[src_idx] == 2'd3);
        if (locked) begin
            ex_st   = ST_LOCKED;
            src_new = src_bal;
            wr_src  = 1'b0;
            wr_dst  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req     <= '0;
            src_idx <= '0;
            dst_idx <= '0;
            st_q    <= ST_OK;
            bal_q   <= '0;
            for (int k = 0; k < NUM_ACC; k++) bal[k] <= BAL_W'(DEF_BAL);
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    req.op     <= req_op;
                    req.acc    <= req_acc;
                    req.dst    <= req_dst_acc;
                    req.pin    <= req_pin;
                    req.amount <= req_amount;
                    if (is_reserved(req_op)) begin
                        st_q  <= ST_BAD_OP;
                        bal_q <= '0;
                    end
                end
                S_SRC_SEARCH: if (s_done) begin
                    src_idx <= s_index;
                    if (!s_found) begin
                        st_q  <= ST_NOT_FOUND;
                        bal_q <= '0;
                    end
                end
                S_DST_SEARCH: if (s_done) begin
                    dst_idx <= s_index;
                    if (!s_found) begin
                        st_q  <= ST_NOT_FOUND;
                        bal_q <= '0;
                    end
                end
                S_EXEC: begin
                    st_q  <= ex_st;
                    bal_q <= src_new;
                    if (wr_src) bal[src_idx] <= src_new;
                    if (wr_dst) bal[dst_idx] <= dst_new;
                end
                default: ;
            endcase
        end
    end

`ifdef LEDGER_LOCKOUT_EN
    // Counter saturates at 3 because a locked account never reaches the AUTH update again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_cnt <= '0;
        end else if (state == S_EXEC && req.op == OP_AUTH && !locked) begin
            if (ex_st == ST_BAD_PIN) bad_cnt[src_idx] <= bad_cnt[src_idx] + 2'd1;
            else                     bad_cnt[src_idx] <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_atm_account_ledger.sv
// Directed bench for atm_account_ledger: latency, arithmetic boundaries, handshake hold,
// mid-request reset and (with LEDGER_LOCKOUT_EN) bad-PIN lockout.
module tb_atm_account_ledger;

    localparam logic [2:0] OPF = 3'd0, OPA = 3'd1, OPR = 3'd2, OPD = 3'd3, OPC = 3'd4, OPT = 3'd5;
    localparam logic [2:0] OK = 3'd0, NF = 3'd1, BP = 3'd2, INS = 3'd3, OVF = 3'd4, BOP = 3'd5, LCK = 3'd6;
    localparam logic [11:0] A0 = 12'd2178, A1 = 12'd2816, A9 = 12'd3333, AX = 12'd2278;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] acc;
        logic [11:0] dst;
        logic [3:0]  pin;
        logic [11:0] amt;
        logic [2:0]  st;
        logic [10:0] bal;
        int          lat;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_op = '0;
    logic [11:0] req_acc = '0, req_dst_acc = '0, req_amount = '0;
    logic [3:0]  req_pin = '0;
    logic        req_ready, rsp_valid;
    logic [2:0]  rsp_status;
    logic [10:0] rsp_balance;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    atm_account_ledger dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_acc     (req_acc),
        .req_pin     (req_pin),
        .req_dst_acc (req_dst_acc),
        .req_amount  (req_amount),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance)
    );

    // Drives one request until accepted, then scrambles the inputs.
    task automatic issue(input logic [2:0] op, input logic [11:0] acc, input logic [11:0] dst,
                         input logic [3:0] pin, input logic [11:0] amt);
        int guard = 0;
        while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        req_valid = 1'b1; req_op = op; req_acc = acc; req_dst_acc = dst; req_pin = pin; req_amount = amt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd7; req_acc = 12'hfff; req_dst_acc = 12'hfff;
        req_pin = 4'hf; req_amount = 12'hfff;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic do_req(input logic [2:0] op, input logic [11:0] acc, input logic [11:0] dst,
                          input logic [3:0] pin, input logic [11:0] amt,
                          output int lat, output logic [2:0] st, output logic [10:0] bal);
        issue(op, acc, dst, pin, amt);
        wait_rsp(lat);
        st  = rsp_status;
        bal = rsp_balance;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_status !== OK) begin errors++; $display("FAIL reset_status got %0d want 0", rsp_status); end
        checks++; if (rsp_balance !== 11'd0) begin errors++; $display("FAIL reset_balance got %0d want 0", rsp_balance); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_auth_debit();
        vec_t v [6];
        int lat; logic [2:0] st; logic [10:0] bal;
        v[0] = '{OPA, AX, 12'd0, 4'b0100, 12'd0,    NF,  11'd0,   11};
        v[1] = '{OPA, A0, 12'd0, 4'b0100, 12'd0,    OK,  11'd500, 3};
        v[2] = '{OPF, A1, 12'd0, 4'b0000, 12'd0,    OK,  11'd500, 4};
        v[3] = '{OPD, A0, 12'd0, 4'b0000, 12'd100,  OK,  11'd400, 3};
        v[4] = '{OPD, A0, 12'd0, 4'b0000, 12'd2500, INS, 11'd400, 3};
        v[5] = '{OPD, A0, 12'd0, 4'b0000, 12'd0,    OK,  11'd400, 3};
        for (int k = 0; k < 6; k++) begin
            do_req(v[k].op, v[k].acc, v[k].dst, v[k].pin, v[k].amt, lat, st, bal);
            checks++; if (st !== v[k].st) begin errors++; $display("FAIL auth_debit[%0d] status got %0d want %0d", k, st, v[k].st); end
            checks++; if (bal !== v[k].bal) begin errors++; $display("FAIL auth_debit[%0d] balance got %0d want %0d", k, bal, v[k].bal); end
            checks++; if (lat != v[k].lat) begin errors++; $display("FAIL auth_debit[%0d] latency got %0d want %0d", k, lat, v[k].lat); end
        end
    endtask

    task automatic test_transfer();
        vec_t v [7];
        int lat; logic [2:0] st; logic [10:0] bal;
        v[0] = '{OPT, A0, A1, 4'b0000, 12'd50,   OK,  11'd350, 5};
        v[1] = '{OPR, A1, 12'd0, 4'b0000, 12'd0, OK,  11'd550, 4};
        v[2] = '{OPT, A0, A1, 4'b0000, 12'd2550, INS, 11'd350, 5};
        v[3] = '{OPR, A0, 12'd0, 4'b0000, 12'd0, OK,  11'd350, 3};
        v[4] = '{OPR, A1, 12'd0, 4'b0000, 12'd0, OK,  11'd550, 4};
        v[5] = '{OPT, A0, AX, 4'b0000, 12'd10,   NF,  11'd0,   12};
        v[6] = '{OPT, A1, A1, 4'b0000, 12'd5,    OK,  11'd550, 6};
        for (int k = 0; k < 7; k++) begin
            do_req(v[k].op, v[k].acc, v[k].dst, v[k].pin, v[k].amt, lat, st, bal);
            checks++; if (st !== v[k].st) begin errors++; $display("FAIL transfer[%0d] status got %0d want %0d", k, st, v[k].st); end
            checks++; if (bal !== v[k].bal) begin errors++; $display("FAIL transfer[%0d] balance got %0d want %0d", k, bal, v[k].bal); end
            checks++; if (lat != v[k].lat) begin errors++; $display("FAIL transfer[%0d] latency got %0d want %0d", k, lat, v[k].lat); end
        end
    endtask

    task automatic test_credit_bounds();
        vec_t v [8];
        int lat; logic [2:0] st; logic [10:0] bal;
        v[0] = '{OPC, A0, 12'd0, 4'b0000, 12'd500,  OK,  11'd850,  3};
        v[1] = '{OPC, A0, 12'd0, 4'b0000, 12'd2550, OVF, 11'd850,  3};
        v[2] = '{OPC, A0, 12'd0, 4'b0000, 12'd1197, OK,  11'd2047, 3};
        v[3] = '{OPC, A0, 12'd0, 4'b0000, 12'd1,    OVF, 11'd2047, 3};
        v[4] = '{OPT, A1, A0, 4'b0000, 12'd1,       OVF, 11'd550,  5};
        v[5] = '{OPR, A9, 12'd0, 4'b0000, 12'd0,    OK,  11'd500,  12};
        v[6] = '{3'd6, A0, 12'd0, 4'b0000, 12'd0,   BOP, 11'd0,    0};
        v[7] = '{OPD, A0, 12'd0, 4'b0000, 12'd2047, OK,  11'd0,    3};
        for (int k = 0; k < 8; k++) begin
            do_req(v[k].op, v[k].acc, v[k].dst, v[k].pin, v[k].amt, lat, st, bal);
            checks++; if (st !== v[k].st) begin errors++; $display("FAIL credit[%0d] status got %0d want %0d", k, st, v[k].st); end
            checks++; if (bal !== v[k].bal) begin errors++; $display("FAIL credit[%0d] balance got %0d want %0d", k, bal, v[k].bal); end
            checks++; if (lat != v[k].lat) begin errors++; $display("FAIL credit[%0d] latency got %0d want %0d", k, lat, v[k].lat); end
        end
    endtask

    task automatic test_hold();
        int lat; logic [2:0] st; logic [10:0] bal;
        rsp_ready = 1'b0;
        issue(OPR, A1, 12'd0, 4'b0000, 12'd0);
        wait_rsp(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL hold_latency got %0d want 4", lat); end
        // A competing request during the hold must be ignored.
        req_valid = 1'b1; req_op = OPD; req_acc = A1; req_amount = 12'd100;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_status, rsp_balance} !== {1'b1, 1'b0, OK, 11'd550}) begin
                errors++;
                $display("FAIL hold[%0d] valid/ready/status/bal got %b/%b/%0d/%0d want 1/0/0/550",
                         c, rsp_valid, req_ready, rsp_status, rsp_balance);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL hold_release valid/ready got %b%b want 01", rsp_valid, req_ready); end
        do_req(OPR, A1, 12'd0, 4'b0000, 12'd0, lat, st, bal);
        checks++; if (bal !== 11'd550) begin errors++; $display("FAIL hold_no_debit balance got %0d want 550", bal); end
    endtask

    task automatic test_reset_mid();
        int lat, seen; logic [2:0] st; logic [10:0] bal;
        issue(OPT, A0, A9, 4'b0000, 12'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL mid_reset valid/ready got %b%b want 01", rsp_valid, req_ready); end
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_reset_abort rsp_valid cycles got %0d want 0", seen); end
        do_req(OPR, A0, 12'd0, 4'b0000, 12'd0, lat, st, bal);
        checks++; if (bal !== 11'd500) begin errors++; $display("FAIL mid_reset_bal0 got %0d want 500", bal); end
        do_req(OPR, A1, 12'd0, 4'b0000, 12'd0, lat, st, bal);
        checks++; if (bal !== 11'd500) begin errors++; $display("FAIL mid_reset_bal1 got %0d want 500", bal); end
        do_req(OPR, A9, 12'd0, 4'b0000, 12'd0, lat, st, bal);
        checks++; if (bal !== 11'd500) begin errors++; $display("FAIL mid_reset_bal9 got %0d want 500", bal); end
    endtask

    task automatic test_lockout();
        int lat; logic [2:0] st; logic [10:0] bal;
        logic [2:0] want_auth, want_debit;
        logic [10:0] want_debit_bal;
`ifdef LEDGER_LOCKOUT_EN
        want_auth = LCK; want_debit = LCK; want_debit_bal = 11'd500;
`else
        want_auth = OK;  want_debit = OK;  want_debit_bal = 11'd400;
`endif
        for (int k = 0; k < 3; k++) begin
            do_req(OPA, A0, 12'd0, 4'b0000, 12'd0, lat, st, bal);
            checks++; if (st !== BP) begin errors++; $display("FAIL lockout_badpin[%0d] status got %0d want 2", k, st); end
        end
        do_req(OPA, A0, 12'd0, 4'b0100, 12'd0, lat, st, bal);
        checks++; if (st !== want_auth) begin errors++; $display("FAIL lockout_auth status got %0d want %0d", st, want_auth); end
        do_req(OPD, A0, 12'd0, 4'b0000, 12'd100, lat, st, bal);
        checks++; if (st !== want_debit) begin errors++; $display("FAIL lockout_debit status got %0d want %0d", st, want_debit); end
        checks++; if (bal !== want_debit_bal) begin errors++; $display("FAIL lockout_debit balance got %0d want %0d", bal, want_debit_bal); end
        do_req(OPT, A1, A0, 4'b0000, 12'd100, lat, st, bal);
        checks++; if ({st, bal} !== {OK, 11'd400}) begin errors++; $display("FAIL lockout_into_dst status/bal got %0d/%0d want 0/400", st, bal); end
    endtask

    initial begin
        test_reset();
        test_auth_debit();
        test_transfer();
        test_credit_bounds();
        test_hold();
        test_reset_mid();
        test_lockout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
